csr_regfile: RTL and testbench
==============================

CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter CsrDataWidth, default 32, CSR data word width.
REQ-002 SHALL have parameter CsrAddrWidth, default 32, CSR address width.
REQ-003 SHALL have parameter NumTotRegs, default 21, number of implemented registers (addresses 0..20).
REQ-004 SHALL have ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  synchronous, active-high reset.
- csr_req_addr_i  in  CsrAddrWidth  request address.
- csr_req_data_i  in  CsrDataWidth  write data.
- csr_req_write_i  in  1  1 = write, 0 = read.
- csr_req_valid_i / csr_req_ready_o  in / out  1  request handshake.
- csr_rsp_data_o  out  CsrDataWidth  read data; 0 for writes.
- csr_rsp_valid_o / csr_rsp_ready_i  out / in  1  response handshake.
- csr_set_o  out  NumTotRegs*CsrDataWidth  flattened register contents, register n at bits [n*32 +: 32].
- start_core_o, core_clr_o, inst_clr_o  out  1  one-cycle command pulses.
- inst_wr_valid_o  out  1  one-cycle instruction-write strobe.
- inst_wr_addr_o  out  CsrDataWidth  instruction-write address.
- inst_wr_data_o  out  CsrDataWidth  instruction-write data.
- core_busy_i  in  1  core busy status.
- am_predict_i  in  8  prediction value.
- am_predict_valid_i  in  1  prediction strobe.
- inst_pc_i, inst_at_addr_i, observable_i  in  CsrDataWidth  read-only status inputs.

Function
REQ-005 SHALL allow one outstanding transaction: csr_req_ready_o = !csr_rsp_valid_o.
REQ-006 SHALL accept a request on valid&ready, then assert csr_rsp_valid_o the next cycle and hold csr_rsp_valid_o and csr_rsp_data_o stable until csr_rsp_ready_i.
REQ-007 SHALL, on an accepted read, return the register value sampled at acceptance; an address >= NumTotRegs SHALL read 0, and a write to it SHALL be ignored (response still given).
REQ-008 SHALL treat addresses 1, 4, 9-19 as full read-write; register 3 bits 0-1 as read-write.
REQ-009 SHALL treat reg 0 bit 1 (busy) as read-only, mirroring core_busy_i; writes to it SHALL be ignored.
REQ-010 SHALL treat reg 0 bit 0 (start) as self-clearing: a write of 1 pulses start_core_o for the cycle after acceptance, and the bit SHALL read 0; if core_busy_i=1 at acceptance, no pulse SHALL occur.
REQ-011 SHALL treat reg 0 bit 6 (core clr) and reg 3 bit 2 (inst clr) as self-clearing: a write of 1 pulses core_clr_o / inst_clr_o the cycle after acceptance, and the bit SHALL read 0.
REQ-012 SHALL treat the remaining reg 0 bits (2-5, 7-31) as read-write.
REQ-013 SHALL treat reg 2 as read-only: [7:0] latches am_predict_i when am_predict_valid_i=1, and bit 8 is a sticky valid flag.
REQ-014 SHALL clear the reg 2 valid flag on an accepted read of reg 2; if am_predict_valid_i=1 in the same cycle, the new value SHALL latch and the flag SHALL remain 1.
REQ-015 SHALL present inst_pc_i, inst_at_addr_i and observable_i as read-only regs 7, 8 and 20; writes to them SHALL be ignored.
REQ-016 SHALL, on a write to reg 5, store the data and then, the next cycle, pulse inst_wr_valid_o with inst_wr_addr_o = reg 4 and inst_wr_data_o = the written data.
REQ-017 SHALL, in the same cycle as the REQ-016 strobe, increment reg 4 by 1, wrapping modulo 2^32 (0xFFFFFFFF -> 0).
REQ-018 SHALL, on a request accepted in the cycle a response completes, not occur; ready stays low that cycle (no bypass).

Reset
REQ-019 SHALL, on rst_i=1 at a clock edge, zero all registers, drop any pending response, and deassert all pulses and csr_rsp_valid_o.
REQ-020 SHALL hold csr_req_ready_o=1 and all other outputs at 0 in the first cycle after reset.

Structure
REQ-021 SHALL take all register and bit addresses from the shared CSR address package; no local literals.
REQ-022 SHALL put the access-type enum (RW, RO, SC) and a per-register access table in that shared package.
REQ-023 SHALL implement in a single module with no sub-modules.

Verification
REQ-024 SHALL cover: write reg 9 = 0xDEADBEEF, then read reg 9 -> rsp 0xDEADBEEF; rsp held 3 cycles with ready low.
REQ-025 SHALL cover: write reg 0 = 0x41 with core_busy_i=0 -> start_core_o and core_clr_o each high 1 cycle, then read reg 0 = 0x0.
REQ-026 SHALL cover: core_busy_i=1, write reg 0 = 0x1 -> no start_core_o pulse, and a read returns 0x2.
REQ-027 SHALL cover: am_predict_i=0x2A pulsed, then read reg 2 twice -> 0x12A then 0x02A; predict valid coincident with read -> flag stays 1.
REQ-028 SHALL cover: reg 4 = 0xFFFFFFFF, two writes to reg 5 -> strobes at addr 0xFFFFFFFF then 0x0.
REQ-029 SHALL cover: read addr 25 -> 0; reset asserted while rsp pending -> rsp_valid 0 and ready 1 next cycle.

Source files
------------

// File: rtl/csr_regfile_pkg.sv
// ---------------------------------------------------------------------------
// csr_regfile_pkg
// Shared CSR map for csr_regfile: register indices, bit positions, the
// access-type enum, the per-register access table and the write-mask helper
// derived from it. Anything that needs a CSR address or bit position takes it
// from here.
// ---------------------------------------------------------------------------
package csr_regfile_pkg;

    localparam int CSR_DW       = 32;
    localparam int CSR_NUM_REGS = 21;
    localparam int CSR_IDX_W    = 5;

    typedef enum logic [1:0] {
        CSR_ACC_RW = 2'd0,   // plain read-write storage
        CSR_ACC_RO = 2'd1,   // status, writes ignored
        CSR_ACC_SC = 2'd2    // mixed register carrying self-clearing command bits
    } csr_access_e;

    // Register indices with special behaviour
    localparam logic [CSR_IDX_W-1:0] CSR_CTRL         = 5'd0;
    localparam logic [CSR_IDX_W-1:0] CSR_PREDICT      = 5'd2;
    localparam logic [CSR_IDX_W-1:0] CSR_INST_CTRL    = 5'd3;
    localparam logic [CSR_IDX_W-1:0] CSR_INST_ADDR    = 5'd4;
    localparam logic [CSR_IDX_W-1:0] CSR_INST_DATA    = 5'd5;
    localparam logic [CSR_IDX_W-1:0] CSR_INST_PC      = 5'd7;
    localparam logic [CSR_IDX_W-1:0] CSR_INST_AT_ADDR = 5'd8;
    localparam logic [CSR_IDX_W-1:0] CSR_OBSERVABLE   = 5'd20;

    // Bit positions
    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_BUSY_BIT     = 1;
    localparam int CTRL_CORE_CLR_BIT = 6;
    localparam int INST_CLR_BIT      = 2;
    localparam int PREDICT_VALUE_W   = 8;
    localparam int PREDICT_VALID_BIT = 8;

    // Writable bits of the mixed registers: control keeps start(0), busy(1)
    // and core-clear(6) out of storage; instruction control stores bits 1:0.
    localparam logic [CSR_DW-1:0] CTRL_RW_MASK      = 32'hFFFF_FFBC;
    localparam logic [CSR_DW-1:0] INST_CTRL_RW_MASK = 32'h0000_0003;

    // Per-register access table, index 0..20
    localparam csr_access_e CSR_ACCESS [CSR_NUM_REGS] = '{
        CSR_ACC_SC,                                         // 0  control
        CSR_ACC_RW,                                         // 1  scratch
        CSR_ACC_RO,                                         // 2  prediction
        CSR_ACC_SC,                                         // 3  instruction control
        CSR_ACC_RW, CSR_ACC_RW, CSR_ACC_RW,                 // 4  inst addr, 5 inst data, 6
        CSR_ACC_RO, CSR_ACC_RO,                             // 7  inst pc, 8 inst at addr
        CSR_ACC_RW, CSR_ACC_RW, CSR_ACC_RW, CSR_ACC_RW,     // 9..12
        CSR_ACC_RW, CSR_ACC_RW, CSR_ACC_RW, CSR_ACC_RW,     // 13..16
        CSR_ACC_RW, CSR_ACC_RW, CSR_ACC_RW,                 // 17..19
        CSR_ACC_RO                                          // 20 observable
    };

    // Bits of register idx that a bus write may store
    function automatic logic [CSR_DW-1:0] csr_wr_mask(input logic [CSR_IDX_W-1:0] idx);
        logic [CSR_DW-1:0] mask;
        mask = '0;
        case (CSR_ACCESS[idx])
            CSR_ACC_RW: mask = '1;
            CSR_ACC_RO: mask = '0;
            CSR_ACC_SC: begin
                case (idx)
                    CSR_CTRL:      mask = CTRL_RW_MASK;
                    CSR_INST_CTRL: mask = INST_CTRL_RW_MASK;
                    default:       mask = '0;
                endcase
            end
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/csr_regfile.sv
// ---------------------------------------------------------------------------
// csr_regfile
// Control/status register file with a single-outstanding valid/ready request
// channel and a valid/ready response channel.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   csr_req_*                    request: addr, data, write, valid / ready
//   csr_rsp_*                    response: data, valid / ready
//   csr_set_o                    all register contents, reg n at [n*W +: W]
//   start_core_o, core_clr_o,
//   inst_clr_o                   one-cycle command pulses
//   inst_wr_valid/addr/data_o    instruction-write strobe with address/data
//   core_busy_i, am_predict_*,
//   inst_pc_i, inst_at_addr_i,
//   observable_i                 status inputs mirrored into read-only regs
// ---------------------------------------------------------------------------
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int CsrDataWidth = 32,
    parameter int CsrAddrWidth = 32,
    parameter int NumTotRegs   = 21
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [CsrAddrWidth-1:0]            csr_req_addr_i,
    input  logic [CsrDataWidth-1:0]            csr_req_data_i,
    input  logic                               csr_req_write_i,
    input  logic                               csr_req_valid_i,
    output logic                               csr_req_ready_o,
    output logic [CsrDataWidth-1:0]            csr_rsp_data_o,
    output logic                               csr_rsp_valid_o,
    input  logic                               csr_rsp_ready_i,
    output logic [NumTotRegs*CsrDataWidth-1:0] csr_set_o,
    output logic                               start_core_o,
    output logic                               core_clr_o,
    output logic                               inst_clr_o,
    output logic                               inst_wr_valid_o,
    output logic [CsrDataWidth-1:0]            inst_wr_addr_o,
    output logic [CsrDataWidth-1:0]            inst_wr_data_o,
    input  logic                               core_busy_i,
    input  logic [7:0]                         am_predict_i,
    input  logic                               am_predict_valid_i,
    input  logic [CsrDataWidth-1:0]            inst_pc_i,
    input  logic [CsrDataWidth-1:0]            inst_at_addr_i,
    input  logic [CsrDataWidth-1:0]            observable_i
);

    logic [CsrDataWidth-1:0] regs_r      [NumTotRegs];
    logic [CsrDataWidth-1:0] regs_next_s [NumTotRegs];

    logic                    rsp_valid_r;
    logic [CsrDataWidth-1:0] rsp_data_r;
    logic                    start_core_r;
    logic                    core_clr_r;
    logic                    inst_clr_r;
    logic                    inst_wr_pend_r;
    logic                    inst_wr_valid_r;
    logic [CsrDataWidth-1:0] inst_wr_addr_r;
    logic [CsrDataWidth-1:0] inst_wr_data_r;

    logic                    accept_s;
    logic                    hit_s;
    logic                    wr_s;
    logic                    rd_s;
    logic [CSR_IDX_W-1:0]    idx_s;
    logic [CsrDataWidth-1:0] rd_val_s;
    logic                    start_next_s;
    logic                    core_clr_next_s;
    logic                    inst_clr_next_s;
    logic                    inst_wr_pend_next_s;

    // Request decode; ready comes straight from the response flop, so a
    // response completing this cycle still blocks a new request.
    always_comb begin
        accept_s = csr_req_valid_i & ~rsp_valid_r;
        hit_s    = (csr_req_addr_i < CsrAddrWidth'(NumTotRegs));
        idx_s    = csr_req_addr_i[CSR_IDX_W-1:0];
        wr_s     = accept_s & hit_s & csr_req_write_i;
        rd_s     = accept_s & hit_s & ~csr_req_write_i;
    end

    // Read mux; out-of-range addresses select nothing and read zero
    always_comb begin
        rd_val_s = '0;
        for (int n = 0; n < NumTotRegs; n++) begin
            rd_val_s = rd_val_s |
                       (((hit_s == 1'b1) && (idx_s == CSR_IDX_W'(n))) ? regs_r[n] : '0);
        end
    end

    // Command pulse requests from the accepted write; start is suppressed while busy
    always_comb begin
        start_next_s        = wr_s & (idx_s == CSR_CTRL) &
                              csr_req_data_i[CTRL_START_BIT] & ~core_busy_i;
        core_clr_next_s     = wr_s & (idx_s == CSR_CTRL) & csr_req_data_i[CTRL_CORE_CLR_BIT];
        inst_clr_next_s     = wr_s & (idx_s == CSR_INST_CTRL) & csr_req_data_i[INST_CLR_BIT];
        inst_wr_pend_next_s = wr_s & (idx_s == CSR_INST_DATA);
    end

    // Register next state: masked bus write, then status mirrors and side effects
    always_comb begin
        logic [CsrDataWidth-1:0] mask_v;
        mask_v = '0;
        for (int n = 0; n < NumTotRegs; n++) begin
            mask_v = (wr_s && (idx_s == CSR_IDX_W'(n))) ?
                     CsrDataWidth'(csr_wr_mask(CSR_IDX_W'(n))) : '0;
            regs_next_s[n] = (regs_r[n] & ~mask_v) | (csr_req_data_i & mask_v);
        end

        regs_next_s[CSR_CTRL][CTRL_BUSY_BIT] = core_busy_i;
        regs_next_s[CSR_INST_PC]             = inst_pc_i;
        regs_next_s[CSR_INST_AT_ADDR]        = inst_at_addr_i;
        regs_next_s[CSR_OBSERVABLE]          = observable_i;

        // A new prediction wins over the read-clear of the sticky flag
        if (am_predict_valid_i) begin
            regs_next_s[CSR_PREDICT][PREDICT_VALUE_W-1:0] = am_predict_i;
            regs_next_s[CSR_PREDICT][PREDICT_VALID_BIT]   = 1'b1;
        end else if (rd_s && (idx_s == CSR_PREDICT)) begin
            regs_next_s[CSR_PREDICT][PREDICT_VALID_BIT]   = 1'b0;
        end else begin
            regs_next_s[CSR_PREDICT][PREDICT_VALID_BIT]   = regs_r[CSR_PREDICT][PREDICT_VALID_BIT];
        end

        // Auto-increment alongside the instruction-write strobe; no bus write
        // can land in that cycle because the response is still outstanding.
        regs_next_s[CSR_INST_ADDR] = regs_next_s[CSR_INST_ADDR] +
                                     {{(CsrDataWidth-1){1'b0}}, inst_wr_pend_r};
    end

    // Register storage
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < NumTotRegs; n++) begin
            if (rst_i) begin
                regs_r[n] <= '0;
            end else begin
                regs_r[n] <= regs_next_s[n];
            end
        end
    end

    // Response channel: data captured at acceptance and held until taken
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
        end else if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= csr_req_write_i ? '0 : rd_val_s;
        end else if (rsp_valid_r && csr_rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
        end
    end

    // Command pulses and the delayed instruction-write strobe
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_core_r    <= 1'b0;
            core_clr_r      <= 1'b0;
            inst_clr_r      <= 1'b0;
            inst_wr_pend_r  <= 1'b0;
            inst_wr_valid_r <= 1'b0;
            inst_wr_addr_r  <= '0;
            inst_wr_data_r  <= '0;
        end else begin
            start_core_r    <= start_next_s;
            core_clr_r      <= core_clr_next_s;
            inst_clr_r      <= inst_clr_next_s;
            inst_wr_pend_r  <= inst_wr_pend_next_s;
            inst_wr_valid_r <= inst_wr_pend_r;
            if (inst_wr_pend_r) begin
                inst_wr_addr_r <= regs_r[CSR_INST_ADDR];
                inst_wr_data_r <= regs_r[CSR_INST_DATA];
            end
        end
    end

    // Flattened view of the register array
    always_comb begin
        csr_set_o = '0;
        for (int n = 0; n < NumTotRegs; n++) begin
            csr_set_o[n*CsrDataWidth +: CsrDataWidth] = regs_r[n];
        end
    end

    assign csr_req_ready_o = ~rsp_valid_r;
    assign csr_rsp_valid_o = rsp_valid_r;
    assign csr_rsp_data_o  = rsp_data_r;
    assign start_core_o    = start_core_r;
    assign core_clr_o      = core_clr_r;
    assign inst_clr_o      = inst_clr_r;
    assign inst_wr_valid_o = inst_wr_valid_r;
    assign inst_wr_addr_o  = inst_wr_addr_r;
    assign inst_wr_data_o  = inst_wr_data_r;

endmodule

// File: tb/tb_csr_regfile.sv
// ---------------------------------------------------------------------------
// tb_csr_regfile
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the register map.
// ---------------------------------------------------------------------------
module tb_csr_regfile;

    localparam int DW = 32;
    localparam int NR = 21;
    localparam int SW = NR * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   addr, data;
    logic          write, req_valid, req_ready;
    logic [31:0]   rsp_data;
    logic          rsp_valid, rsp_ready;
    logic [SW-1:0] set_vec;
    logic          start_core, core_clr, inst_clr;
    logic          inst_wr_valid;
    logic [31:0]   inst_wr_addr, inst_wr_data;
    logic          busy;
    logic [7:0]    pred;
    logic          pred_valid;
    logic [31:0]   pc, at_addr, obs;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_reg [NR];
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;
    logic        m_start, m_core_clr, m_inst_clr;
    logic        m_wr_valid, m_wr_due;
    logic [31:0] m_wr_addr, m_wr_data;

    csr_regfile dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .csr_req_addr_i     (addr),
        .csr_req_data_i     (data),
        .csr_req_write_i    (write),
        .csr_req_valid_i    (req_valid),
        .csr_req_ready_o    (req_ready),
        .csr_rsp_data_o     (rsp_data),
        .csr_rsp_valid_o    (rsp_valid),
        .csr_rsp_ready_i    (rsp_ready),
        .csr_set_o          (set_vec),
        .start_core_o       (start_core),
        .core_clr_o         (core_clr),
        .inst_clr_o         (inst_clr),
        .inst_wr_valid_o    (inst_wr_valid),
        .inst_wr_addr_o     (inst_wr_addr),
        .inst_wr_data_o     (inst_wr_data),
        .core_busy_i        (busy),
        .am_predict_i       (pred),
        .am_predict_valid_i (pred_valid),
        .inst_pc_i          (pc),
        .inst_at_addr_i     (at_addr),
        .observable_i       (obs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [SW-1:0] observed, input logic [SW-1:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        logic [31:0] rd;
        logic        acc;
        if (rst) begin
            for (int i = 0; i < NR; i++) m_reg[i] = 32'd0;
            m_rsp_valid = 1'b0; m_rsp_data = 32'd0;
            m_start = 1'b0; m_core_clr = 1'b0; m_inst_clr = 1'b0;
            m_wr_valid = 1'b0; m_wr_due = 1'b0;
            m_wr_addr = 32'd0; m_wr_data = 32'd0;
        end else begin
            m_start = 1'b0; m_core_clr = 1'b0; m_inst_clr = 1'b0; m_wr_valid = 1'b0;
            acc = req_valid && !m_rsp_valid;
            rd  = (addr < NR) ? m_reg[addr[4:0]] : 32'd0;
            if (m_wr_due) begin
                m_wr_valid = 1'b1;
                m_wr_addr  = m_reg[4];
                m_wr_data  = m_reg[5];
                m_reg[4]   = m_reg[4] + 32'd1;
                m_wr_due   = 1'b0;
            end
            if (acc) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = write ? 32'd0 : rd;
                if (write && addr < NR) begin
                    case (addr)
                        32'd0: begin
                            m_reg[0]   = data & 32'hFFFF_FFBC;
                            m_start    = data[0] & ~busy;
                            m_core_clr = data[6];
                        end
                        32'd3: begin
                            m_reg[3]   = data & 32'h0000_0003;
                            m_inst_clr = data[2];
                        end
                        32'd2, 32'd7, 32'd8, 32'd20: ;
                        32'd5: begin
                            m_reg[5] = data;
                            m_wr_due = 1'b1;
                        end
                        default: m_reg[addr[4:0]] = data;
                    endcase
                end
                if (!write && addr == 32'd2) m_reg[2][8] = 1'b0;
            end else if (m_rsp_valid && rsp_ready) begin
                m_rsp_valid = 1'b0;
                m_rsp_data  = 32'd0;
            end
            m_reg[0][1] = busy;
            m_reg[7]    = pc;
            m_reg[8]    = at_addr;
            m_reg[20]   = obs;
            if (pred_valid) m_reg[2] = {23'd0, 1'b1, pred};
        end
    endtask

    task automatic check_all();
        logic [SW-1:0] flat;
        for (int i = 0; i < NR; i++) flat[i*DW +: DW] = m_reg[i];
        chk("req_ready", req_ready, !m_rsp_valid);
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        if (m_rsp_valid) chk("rsp_data", rsp_data, m_rsp_data);
        chk("start_core", start_core, m_start);
        chk("core_clr", core_clr, m_core_clr);
        chk("inst_clr", inst_clr, m_inst_clr);
        chk("inst_wr_valid", inst_wr_valid, m_wr_valid);
        if (m_wr_valid) begin
            chk("inst_wr_addr", inst_wr_addr, m_wr_addr);
            chk("inst_wr_data", inst_wr_data, m_wr_data);
        end
        chk("csr_set", set_vec, flat);
    endtask

    // Inputs are driven just after a falling edge; outputs checked at the next one
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr = a; write = w; data = d; req_valid = 1'b1; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic fin();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = 32'd0; data = 32'd0; write = 1'b0; req_valid = 1'b0;
        rsp_ready = 1'b0; busy = 1'b0; pred = 8'd0; pred_valid = 1'b0;
        pc = 32'h1234_5678; at_addr = 32'hA5A5_0001; obs = 32'h0BAD_F00D;
        @(negedge clk);
        tick();
        tick();
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_set", set_vec, '0);
        rst = 1'b0;

        // Write/read of a plain register with a held response
        req(32'd9, 1'b1, 32'hDEAD_BEEF); fin();
        req(32'd9, 1'b0, 32'd0);
        chk("r9_data", rsp_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_ready", req_ready, 1'b0);
            chk("hold_data", rsp_data, 32'hDEAD_BEEF);
        end
        fin();
        chk("done_valid", rsp_valid, 1'b0);

        // Start and core-clear pulses, bits read back as zero
        busy = 1'b0;
        req(32'd0, 1'b1, 32'h0000_0041);
        chk("start_pulse", start_core, 1'b1);
        chk("coreclr_pulse", core_clr, 1'b1);
        fin();
        chk("start_end", start_core, 1'b0);
        chk("coreclr_end", core_clr, 1'b0);
        req(32'd0, 1'b0, 32'd0);
        chk("r0_after_sc", rsp_data, 32'd0);
        fin();
        req(32'd3, 1'b1, 32'h0000_0007);
        chk("instclr_pulse", inst_clr, 1'b1);
        fin();
        req(32'd3, 1'b0, 32'd0);
        chk("r3_read", rsp_data, 32'h0000_0003);
        fin();

        // Start suppressed while busy; busy bit visible
        busy = 1'b1;
        tick();
        req(32'd0, 1'b1, 32'h0000_0001);
        chk("busy_nostart", start_core, 1'b0);
        fin();
        req(32'd0, 1'b0, 32'd0);
        chk("r0_busy", rsp_data, 32'h0000_0002);
        fin();
        busy = 1'b0;

        // Prediction latch, sticky flag, read-clear vs new prediction
        pred = 8'h2A; pred_valid = 1'b1;
        tick();
        pred_valid = 1'b0;
        req(32'd2, 1'b0, 32'd0); chk("pred_first", rsp_data, 32'h0000_012A); fin();
        req(32'd2, 1'b0, 32'd0); chk("pred_clr", rsp_data, 32'h0000_002A); fin();
        pred = 8'h55; pred_valid = 1'b1;
        req(32'd2, 1'b0, 32'd0);
        pred_valid = 1'b0;
        chk("pred_coinc_old", rsp_data, 32'h0000_002A);
        fin();
        req(32'd2, 1'b0, 32'd0); chk("pred_coinc_new", rsp_data, 32'h0000_0155); fin();

        // Instruction-write strobes with address wrap
        req(32'd4, 1'b1, 32'hFFFF_FFFF); fin();
        req(32'd5, 1'b1, 32'h0000_0011); fin();
        chk("iw1_valid", inst_wr_valid, 1'b1);
        chk("iw1_addr", inst_wr_addr, 32'hFFFF_FFFF);
        chk("iw1_data", inst_wr_data, 32'h0000_0011);
        req(32'd5, 1'b1, 32'h0000_0022);
        chk("iw_gap", inst_wr_valid, 1'b0);
        fin();
        chk("iw2_valid", inst_wr_valid, 1'b1);
        chk("iw2_addr", inst_wr_addr, 32'h0000_0000);
        chk("iw2_data", inst_wr_data, 32'h0000_0022);
        req(32'd4, 1'b0, 32'd0); chk("r4_after", rsp_data, 32'h0000_0001); fin();

        // Out-of-range accesses and reset while a response is pending
        req(32'd25, 1'b0, 32'd0);
        chk("oor_valid", rsp_valid, 1'b1);
        chk("oor_data", rsp_data, 32'd0);
        fin();
        req(32'h8000_0003, 1'b1, 32'h0000_00FF); fin();
        req(32'd9, 1'b0, 32'd0);
        chk("pend_valid", rsp_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_pend_valid", rsp_valid, 1'b0);
        chk("rst_pend_ready", req_ready, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            req_valid  = 1'($urandom_range(0, 1));
            write      = 1'($urandom_range(0, 1));
            addr       = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 22));
            data       = $urandom;
            rsp_ready  = ($urandom_range(0, 2) != 0);
            busy       = 1'($urandom_range(0, 1));
            pred       = 8'($urandom);
            pred_valid = ($urandom_range(0, 3) == 0);
            pc         = $urandom;
            at_addr    = $urandom;
            obs        = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
